// File: rtl/cam_dvp_tx.sv
// DVP camera-sensor emulator: OV-style vsyn/href timing with RGB565 test patterns,
// two bytes per pixel, high byte first. Every output is a flop fed from the next-cycle position.
module cam_dvp_tx #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          H_BLANK     = 144,
    parameter int          VS_LINES    = 3,
    parameter int          VB_LINES    = 17,
    parameter int          VF_LINES    = 10,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input  logic        cmos_pclk,
    input  logic        rst_133,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        cmos_vsyn,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    localparam int          LINE_LEN  = 2*H_ACTIVE + H_BLANK;
    localparam logic [15:0] LAST_BYTE = 16'(LINE_LEN - 1);
    localparam logic [15:0] HREF_LEN  = 16'(2*H_ACTIVE);
    localparam logic [15:0] BAR_W     = 16'(H_ACTIVE/8);

    // Zero-line states are folded out of the sequence at elaboration time.
    localparam logic [2:0] S_FIRST    = (VS_LINES > 0) ? S_VSYNC :
                                        (VB_LINES > 0) ? S_VBACK : S_ACTIVE;
    localparam logic [2:0] S_AFTER_VS = (VB_LINES > 0) ? S_VBACK : S_ACTIVE;
    localparam logic [2:0] S_LAST     = (VF_LINES > 0) ? S_VFRONT : S_ACTIVE;

    function automatic logic [15:0] last_line(input logic [2:0] s);
        case (s)
            S_VSYNC:  return 16'(VS_LINES - 1);
            S_VBACK:  return 16'(VB_LINES - 1);
            S_ACTIVE: return 16'(V_ACTIVE - 1);
            S_VFRONT: return 16'(VF_LINES - 1);
            default:  return 16'd0;
        endcase
    endfunction

    logic [2:0]  state, nxt_state;
    logic [15:0] byte_cnt, nxt_byte;
    logic [15:0] line_cnt, nxt_line;
    logic [1:0]  pat, nxt_pat;
    logic [15:0] pix_cnt;
    logic        start;

    always_comb begin
        nxt_state = state;
        nxt_byte  = byte_cnt;
        nxt_line  = line_cnt;
        start     = 1'b0;
        if (state == S_IDLE) begin
            if (en) begin
                nxt_state = S_FIRST;
                start     = 1'b1;
            end
        end else if (byte_cnt != LAST_BYTE) begin
            nxt_byte = byte_cnt + 16'd1;
        end else begin
            nxt_byte = '0;
            if (line_cnt != last_line(state)) begin
                nxt_line = line_cnt + 16'd1;
            end else begin
                nxt_line = '0;
                if (state == S_LAST) begin
                    if (en) begin
                        nxt_state = S_FIRST;
                        start     = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end else if (state == S_VSYNC) begin
                    nxt_state = S_AFTER_VS;
                end else if (state == S_VBACK) begin
                    nxt_state = S_ACTIVE;
                end else begin
                    nxt_state = S_VFRONT;
                end
            end
        end
        nxt_pat = start ? pattern_sel : pat;
    end

    logic [15:0] col;
    logic [2:0]  bar;
    logic [15:0] pixel;
    logic        href_n;
    logic        last_n;

    always_comb begin
        col    = nxt_byte >> 1;
        bar    = 3'(col / BAR_W);
        href_n = (nxt_state == S_ACTIVE) && (nxt_byte < HREF_LEN);
        last_n = (nxt_state == S_LAST) && (nxt_line == last_line(S_LAST)) &&
                 (nxt_byte == LAST_BYTE);
        pixel  = 16'h0000;
        case (nxt_pat)
            2'd0: begin
                case (bar)
                    3'd0: pixel = 16'hFFFF;
                    3'd1: pixel = 16'hFFE0;
                    3'd2: pixel = 16'h07FF;
                    3'd3: pixel = 16'h07E0;
                    3'd4: pixel = 16'hF81F;
                    3'd5: pixel = 16'hF800;
                    3'd6: pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = start ? 16'h0000 : pix_cnt;
            2'd2:    pixel = SOLID_COLOR;
            default: pixel = (((col ^ nxt_line) & 16'h0010) != 16'h0000) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            pat        <= '0;
            pix_cnt    <= '0;
            cmos_vsyn  <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= nxt_state;
            byte_cnt   <= nxt_byte;
            line_cnt   <= nxt_line;
            pat        <= nxt_pat;
            cmos_vsyn  <= (nxt_state == S_VSYNC);
            cmos_href  <= href_n;
            cmos_data  <= !href_n ? 8'h00 : (nxt_byte[0] ? pixel[7:0] : pixel[15:8]);
            frame_done <= last_n;
            if (last_n)
                frame_cnt <= frame_cnt + 16'd1;
            // Counter pattern advances after the low byte of each pixel leaves.
            if (start)
                pix_cnt <= '0;
            else if (href_n && nxt_byte[0])
                pix_cnt <= pix_cnt + 16'd1;
        end
    end

endmodule
